// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the FFT stage address generator.
// Holds the sequencer state encoding, the write-back delay-line entry and
// the bit-reverse helper used when FFT_AGU_BITREV_EN folds the input
// permutation into layer 0.
package fft_pkg;

    // Widest sample-RAM address the delay-line entry can carry; the top
    // level zero-extends its ADDR_SIZE-wide addresses into these fields.
    localparam int AGU_ADDR_W = 16;
    localparam int AGU_IDX_W  = $clog2(AGU_ADDR_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } agu_state_t;

    // One in-flight butterfly: write enable plus both write-back addresses.
    typedef struct packed {
        logic                  valid;
        logic [AGU_ADDR_W-1:0] addrA;
        logic [AGU_ADDR_W-1:0] addrB;
    } agu_wb_t;

    // Reverse the low 'bits' bits of v; bits above that come back as zero.
    function automatic logic [AGU_ADDR_W-1:0] bitrev(
        input logic [AGU_ADDR_W-1:0] v,
        input int unsigned           bits
    );
        logic [AGU_ADDR_W-1:0] r;
        logic [AGU_IDX_W-1:0]  idx;
        r = '0;
        for (int i = 0; i < AGU_ADDR_W; i++) begin
            idx = AGU_IDX_W'(int'(bits) - 1 - i);
            if (i < int'(bits)) begin
                r[i] = v[idx];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_stage_agu_delay.sv
// fft_addr_delay: DEPTH-stage shift register carrying {valid, addrA, addrB}
// so write-back addresses line up with the butterfly pipeline output.
// o_pending reports whether any entry other than the one currently on the
// output is still valid, which tells the sequencer the line is draining.
module fft_addr_delay
    import fft_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  agu_wb_t           i_entry,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addrA,
    output logic [ADDR_W-1:0] o_addrB,
    output logic              o_pending
);

    agu_wb_t r_stage [DEPTH];

    // Shift every entry one stage per clock; reset flushes in-flight writes.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_entry;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_valid = r_stage[DEPTH-1].valid;
    assign o_addrA = r_stage[DEPTH-1].addrA[ADDR_W-1:0];
    assign o_addrB = r_stage[DEPTH-1].addrB[ADDR_W-1:0];

    generate
        if (DEPTH > 1) begin : g_pending
            // Any valid entry still behind the output stage keeps us draining.
            always_comb begin
                o_pending = 1'b0;
                for (int i = 0; i < DEPTH-1; i++) begin
                    o_pending = o_pending | r_stage[i].valid;
                end
            end
        end else begin : g_noPending
            assign o_pending = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/fft_stage_agu.sv
// fft_stage_agu: runtime-programmable address generator for one in-place
// radix-2 FFT stage. A start handshake latches the layer, then N/2
// butterflies are issued (A, B and twiddle addresses), and the matching
// write-back addresses emerge PIPE_LAT cycles later.
// Optional macro FFT_AGU_BITREV_EN: layer-0 reads use bit-reversed
// addresses so the input permutation is folded into the first stage.
module fft_stage_agu
    import fft_pkg::*;
#(
    parameter int FFT_SIZE       = 16,
    parameter int ADDR_SIZE      = 5,
    parameter int MEM_OFFSET     = 0,
    parameter int PIPE_LAT       = 2,
    parameter int LOG2N          = $clog2(FFT_SIZE),
    parameter int TWID_ADDR_SIZE = LOG2N - 1
) (
    input  logic                       i_CLK,
    input  logic                       i_RST,
    input  logic                       i_start,
    input  logic [$clog2(LOG2N)-1:0]   i_layer,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_rden,
    output logic [ADDR_SIZE-1:0]       o_rdaddr_A,
    output logic [ADDR_SIZE-1:0]       o_rdaddr_B,
    output logic [TWID_ADDR_SIZE-1:0]  o_rdaddr_tw,
    output logic                       o_wren,
    output logic [ADDR_SIZE-1:0]       o_wraddr_A,
    output logic [ADDR_SIZE-1:0]       o_wraddr_B
);

    localparam int LW = $clog2(LOG2N);
    localparam logic [LOG2N-1:0] HALF_N = LOG2N'(FFT_SIZE / 2);

    agu_state_t                r_state;
    logic [LW-1:0]             r_layer;
    logic [LOG2N-1:0]          r_k;
    logic                      r_rden;
    logic                      r_done;
    logic [ADDR_SIZE-1:0]      r_rdA;
    logic [ADDR_SIZE-1:0]      r_rdB;
    logic [TWID_ADDR_SIZE-1:0] r_tw;

    logic [LOG2N-1:0]          w_kSel;
    logic [LW-1:0]             w_layerSel;
    logic [LW:0]               w_shiftUp;
    logic [LW-1:0]             w_twShift;
    logic [LOG2N-1:0]          w_half;
    logic [LOG2N-1:0]          w_mask;
    logic [LOG2N-1:0]          w_aIdx;
    logic [LOG2N-1:0]          w_bIdx;
    logic [ADDR_SIZE-1:0]      w_rdA;
    logic [ADDR_SIZE-1:0]      w_rdB;
    logic [TWID_ADDR_SIZE-1:0] w_tw;
    logic [ADDR_SIZE-1:0]      w_wbA;
    logic [ADDR_SIZE-1:0]      w_wbB;
    logic                      w_layerOk;
    logic                      w_pending;
    agu_wb_t                   w_entry;

`ifdef FFT_AGU_BITREV_EN
    logic [ADDR_SIZE-1:0]      r_wbA;
    logic [ADDR_SIZE-1:0]      r_wbB;
    logic [ADDR_SIZE-1:0]      w_natA;
    logic [ADDR_SIZE-1:0]      w_natB;
`endif

    assign w_layerOk = (32'(i_layer) < LOG2N);

    // Butterfly index arithmetic for the butterfly about to be issued: in IDLE
    // that is k=0 of the requested layer, otherwise the running counter.
    always_comb begin
        w_kSel     = (r_state == ST_IDLE) ? '0 : r_k;
        w_layerSel = (r_state == ST_IDLE) ? i_layer : r_layer;
        w_shiftUp  = {1'b0, w_layerSel} + (LW+1)'(1);
        w_twShift  = LW'(LOG2N - 1) - w_layerSel;
        w_half     = LOG2N'(1) << w_layerSel;
        w_mask     = w_half - LOG2N'(1);
        w_aIdx     = ((w_kSel >> w_layerSel) << w_shiftUp) | (w_kSel & w_mask);
        w_bIdx     = w_aIdx + w_half;
        w_tw       = TWID_ADDR_SIZE'((w_kSel & w_mask) << w_twShift);
`ifdef FFT_AGU_BITREV_EN
        w_natA     = ADDR_SIZE'(w_aIdx) + ADDR_SIZE'(MEM_OFFSET);
        w_natB     = ADDR_SIZE'(w_bIdx) + ADDR_SIZE'(MEM_OFFSET);
        if (w_layerSel == '0) begin
            w_rdA = ADDR_SIZE'(LOG2N'(bitrev(AGU_ADDR_W'(w_aIdx), LOG2N))) + ADDR_SIZE'(MEM_OFFSET);
            w_rdB = ADDR_SIZE'(LOG2N'(bitrev(AGU_ADDR_W'(w_bIdx), LOG2N))) + ADDR_SIZE'(MEM_OFFSET);
        end else begin
            w_rdA = w_natA;
            w_rdB = w_natB;
        end
`else
        w_rdA      = ADDR_SIZE'(w_aIdx) + ADDR_SIZE'(MEM_OFFSET);
        w_rdB      = ADDR_SIZE'(w_bIdx) + ADDR_SIZE'(MEM_OFFSET);
`endif
    end

    // Sequencer: accept a legal start, issue N/2 reads, wait for the delay
    // line to empty, pulse done. Read addresses only change when issued.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state <= ST_IDLE;
            r_layer <= '0;
            r_k     <= '0;
            r_rden  <= 1'b0;
            r_done  <= 1'b0;
            r_rdA   <= '0;
            r_rdB   <= '0;
            r_tw    <= '0;
`ifdef FFT_AGU_BITREV_EN
            r_wbA   <= '0;
            r_wbB   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start && w_layerOk) begin
                        r_layer <= i_layer;
                        r_k     <= LOG2N'(1);
                        r_rden  <= 1'b1;
                        r_rdA   <= w_rdA;
                        r_rdB   <= w_rdB;
                        r_tw    <= w_tw;
`ifdef FFT_AGU_BITREV_EN
                        r_wbA   <= w_natA;
                        r_wbB   <= w_natB;
`endif
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (r_k == HALF_N) begin
                        r_rden  <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_rden  <= 1'b1;
                        r_rdA   <= w_rdA;
                        r_rdB   <= w_rdB;
                        r_tw    <= w_tw;
`ifdef FFT_AGU_BITREV_EN
                        r_wbA   <= w_natA;
                        r_wbB   <= w_natB;
`endif
                        r_k     <= r_k + LOG2N'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!w_pending) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FFT_AGU_BITREV_EN
    assign w_wbA = r_wbA;
    assign w_wbB = r_wbB;
`else
    assign w_wbA = r_rdA;
    assign w_wbB = r_rdB;
`endif

    assign w_entry.valid = r_rden;
    assign w_entry.addrA = AGU_ADDR_W'(w_wbA);
    assign w_entry.addrB = AGU_ADDR_W'(w_wbB);

    fft_addr_delay #(
        .DEPTH  (PIPE_LAT),
        .ADDR_W (ADDR_SIZE)
    ) u_delay (
        .i_CLK     (i_CLK),
        .i_RST     (i_RST),
        .i_entry   (w_entry),
        .o_valid   (o_wren),
        .o_addrA   (o_wraddr_A),
        .o_addrB   (o_wraddr_B),
        .o_pending (w_pending)
    );

    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_rden      = r_rden;
    assign o_rdaddr_A  = r_rdA;
    assign o_rdaddr_B  = r_rdB;
    assign o_rdaddr_tw = r_tw;

endmodule

// File: tb/tb_fft_stage_agu.sv
// tb_fft_stage_agu: scoreboard bench for fft_stage_agu at N=8, PIPE_LAT=2.
// Two instances share the stimulus: one at MEM_OFFSET=0, one at MEM_OFFSET=8.
// Stimulus pushes hand-computed reads, writes and done cycles into per-DUT
// queues; a negedge monitor pops and compares whatever the DUTs present.
// Honours FFT_AGU_BITREV_EN for the layer-0 read order.
module tb_fft_stage_agu;

    localparam int N    = 8;
    localparam int PL   = 2;
    localparam int AW   = 5;
    localparam int LW   = 2;
    localparam int TW   = 2;
    localparam int OFF1 = 8;

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
    } rdExp_t;

    typedef struct {
        int cyc;
        int a;
        int b;
    } wrExp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [LW-1:0] layer;

    logic          busy [2];
    logic          done [2];
    logic          rden [2];
    logic          wren [2];
    logic [AW-1:0] rdA  [2];
    logic [AW-1:0] rdB  [2];
    logic [TW-1:0] rdTw [2];
    logic [AW-1:0] wrA  [2];
    logic [AW-1:0] wrB  [2];

    rdExp_t rdQ   [2][$];
    wrExp_t wrQ   [2][$];
    int     doneQ [2][$];

    int cycleCnt = 0;
    int nChecks  = 0;
    int nErrors  = 0;
    int eStart;

    // Hand-computed butterfly vectors for N=8.
    int natA0 [4] = '{0, 2, 4, 6};
    int natB0 [4] = '{1, 3, 5, 7};
    int tw0   [4] = '{0, 0, 0, 0};
`ifdef FFT_AGU_BITREV_EN
    int rdA0  [4] = '{0, 2, 1, 3};
    int rdB0  [4] = '{4, 6, 5, 7};
`else
    int rdA0  [4] = '{0, 2, 4, 6};
    int rdB0  [4] = '{1, 3, 5, 7};
`endif
    int natA1 [4] = '{0, 1, 4, 5};
    int natB1 [4] = '{2, 3, 6, 7};
    int tw1   [4] = '{0, 2, 0, 2};
    int natA2 [4] = '{0, 1, 2, 3};
    int natB2 [4] = '{4, 5, 6, 7};
    int tw2   [4] = '{0, 1, 2, 3};

    always #5 clk = ~clk;

    // Cycle counter used to timestamp expectations and observations.
    always @(posedge clk) begin
        cycleCnt = cycleCnt + 1;
    end

    fft_stage_agu #(
        .FFT_SIZE (N), .ADDR_SIZE (AW), .MEM_OFFSET (0), .PIPE_LAT (PL)
    ) dut0 (
        .i_CLK (clk), .i_RST (rst), .i_start (start), .i_layer (layer),
        .o_busy (busy[0]), .o_done (done[0]), .o_rden (rden[0]),
        .o_rdaddr_A (rdA[0]), .o_rdaddr_B (rdB[0]), .o_rdaddr_tw (rdTw[0]),
        .o_wren (wren[0]), .o_wraddr_A (wrA[0]), .o_wraddr_B (wrB[0])
    );

    fft_stage_agu #(
        .FFT_SIZE (N), .ADDR_SIZE (AW), .MEM_OFFSET (OFF1), .PIPE_LAT (PL)
    ) dut1 (
        .i_CLK (clk), .i_RST (rst), .i_start (start), .i_layer (layer),
        .o_busy (busy[1]), .o_done (done[1]), .o_rden (rden[1]),
        .o_rdaddr_A (rdA[1]), .o_rdaddr_B (rdB[1]), .o_rdaddr_tw (rdTw[1]),
        .o_wren (wren[1]), .o_wraddr_A (wrA[1]), .o_wraddr_B (wrB[1])
    );

    // Monitor: flag expectations whose cycle has passed, then pop and compare
    // every read, write and done the DUTs present.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            while (rdQ[d].size() > 0 && rdQ[d][0].cyc < cycleCnt) begin
                nChecks++; nErrors++;
                $display("[TB] FAIL rd_missing dut%0d: got no read, required A=%0d at cycle %0d", d, rdQ[d][0].a, rdQ[d][0].cyc);
                void'(rdQ[d].pop_front());
            end
            while (wrQ[d].size() > 0 && wrQ[d][0].cyc < cycleCnt) begin
                nChecks++; nErrors++;
                $display("[TB] FAIL wr_missing dut%0d: got no write, required A=%0d at cycle %0d", d, wrQ[d][0].a, wrQ[d][0].cyc);
                void'(wrQ[d].pop_front());
            end
            while (doneQ[d].size() > 0 && doneQ[d][0] < cycleCnt) begin
                nChecks++; nErrors++;
                $display("[TB] FAIL done_missing dut%0d: got no done, required at cycle %0d", d, doneQ[d][0]);
                void'(doneQ[d].pop_front());
            end
            if (rden[d]) begin
                rdExp_t e;
                nChecks++;
                if (rdQ[d].size() == 0) begin
                    nErrors++;
                    $display("[TB] FAIL rd_unexpected dut%0d: got read A=%0d B=%0d at cycle %0d, required none", d, rdA[d], rdB[d], cycleCnt);
                end else begin
                    e = rdQ[d].pop_front();
                    if (e.cyc != cycleCnt || rdA[d] !== AW'(e.a) || rdB[d] !== AW'(e.b) || rdTw[d] !== TW'(e.tw)) begin
                        nErrors++;
                        $display("[TB] FAIL rd dut%0d: got cyc=%0d A=%0d B=%0d tw=%0d, required cyc=%0d A=%0d B=%0d tw=%0d",
                                 d, cycleCnt, rdA[d], rdB[d], rdTw[d], e.cyc, e.a, e.b, e.tw);
                    end
                end
            end
            if (wren[d]) begin
                wrExp_t w;
                nChecks++;
                if (wrQ[d].size() == 0) begin
                    nErrors++;
                    $display("[TB] FAIL wr_unexpected dut%0d: got write A=%0d B=%0d at cycle %0d, required none", d, wrA[d], wrB[d], cycleCnt);
                end else begin
                    w = wrQ[d].pop_front();
                    if (w.cyc != cycleCnt || wrA[d] !== AW'(w.a) || wrB[d] !== AW'(w.b)) begin
                        nErrors++;
                        $display("[TB] FAIL wr dut%0d: got cyc=%0d A=%0d B=%0d, required cyc=%0d A=%0d B=%0d",
                                 d, cycleCnt, wrA[d], wrB[d], w.cyc, w.a, w.b);
                    end
                end
            end
            if (done[d]) begin
                int c;
                nChecks++;
                if (doneQ[d].size() == 0) begin
                    nErrors++;
                    $display("[TB] FAIL done_unexpected dut%0d: got done at cycle %0d, required none", d, cycleCnt);
                end else begin
                    c = doneQ[d].pop_front();
                    if (c != cycleCnt || busy[d] !== 1'b1) begin
                        nErrors++;
                        $display("[TB] FAIL done dut%0d: got cyc=%0d busy=%0b, required cyc=%0d busy=1", d, cycleCnt, busy[d], c);
                    end
                end
            end
        end
    end

    // Pack every output of one DUT into a single word for static checks.
    function automatic logic [63:0] packOut(input int d);
        return 64'({busy[d], done[d], rden[d], wren[d], rdA[d], rdB[d], rdTw[d], wrA[d], wrB[d]});
    endfunction

    // Static comparison used for reset state, busy and hold checks.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Issue one start for 'lay' and queue the expected read/write/done
    // stream for both DUTs. abortAt >= 0 drops everything from that
    // relative cycle on (reset planned there), including the done pulse.
    task automatic applyStimulus(input int lay, input int ra[4], input int rb[4], input int tws[4],
                                 input int wa[4], input int wb[4], input int abortAt, output int eAcc);
        int off;
        @(negedge clk);
        layer = lay[LW-1:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        eAcc  = cycleCnt;
        for (int d = 0; d < 2; d++) begin
            off = (d == 1) ? OFF1 : 0;
            for (int k = 0; k < N/2; k++) begin
                if (abortAt < 0 || k < abortAt) begin
                    rdQ[d].push_back('{eAcc + k, ra[k] + off, rb[k] + off, tws[k]});
                end
                if (abortAt < 0 || k + PL < abortAt) begin
                    wrQ[d].push_back('{eAcc + k + PL, wa[k] + off, wb[k] + off});
                end
            end
            if (abortAt < 0) begin
                doneQ[d].push_back(eAcc + N/2 + PL);
            end
        end
    endtask

    // Wait (bounded) for both DUTs to return to idle.
    task automatic waitIdle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = !busy[0] && !busy[1];
        end
        nChecks++;
        if (!ok) begin
            nErrors++;
            $display("[TB] FAIL %s: got busy=%0b/%0b after 60 cycles, required 0/0", name, busy[0], busy[1]);
        end
    endtask

    // Wait (bounded) for the done pulse of DUT 0, returning on its negedge.
    task automatic waitDone(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = done[0];
        end
        nChecks++;
        if (!seen) begin
            nErrors++;
            $display("[TB] FAIL %s: got done=0 after 60 cycles, required 1", name);
        end
    endtask

    // Hard stop in case something wedges the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion by time 100000, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        layer = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state_dut0", packOut(0), 64'd0);
        checkOutput("reset_state_dut1", packOut(1), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] layer 0");
        applyStimulus(0, rdA0, rdB0, tw0, natA0, natB0, -1, eStart);
        @(negedge clk);
        checkOutput("busy_after_accept", 64'({busy[0], busy[1]}), 64'd3);
        waitIdle("idle_layer0");

        $display("[TB] layer 1 then layer 2 back to back");
        applyStimulus(1, natA1, natB1, tw1, natA1, natB1, -1, eStart);
        waitDone("done_layer1");
        @(posedge clk);
        applyStimulus(2, natA2, natB2, tw2, natA2, natB2, -1, eStart);
        waitIdle("idle_layer2");
        checkOutput("hold_rd_dut0", 64'({rdA[0], rdB[0], rdTw[0]}), 64'({AW'(3), AW'(7), TW'(3)}));
        checkOutput("hold_rd_dut1", 64'({rdA[1], rdB[1], rdTw[1]}), 64'({AW'(OFF1 + 3), AW'(OFF1 + 7), TW'(3)}));

        $display("[TB] illegal layer");
        @(negedge clk);
        layer = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("illegal_layer_busy", 64'({busy[0], busy[1]}), 64'd0);
        repeat (4) @(negedge clk);

        $display("[TB] start during read");
        applyStimulus(2, natA2, natB2, tw2, natA2, natB2, -1, eStart);
        @(negedge clk);
        @(negedge clk);
        layer = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle("idle_start_in_read");
        repeat (4) @(negedge clk);

        $display("[TB] reset mid layer 1");
        applyStimulus(1, natA1, natB1, tw1, natA1, natB1, 3, eStart);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrun_reset_dut0", packOut(0), 64'd0);
        checkOutput("midrun_reset_dut1", packOut(1), 64'd0);
        repeat (4) @(negedge clk);
        applyStimulus(0, rdA0, rdB0, tw0, natA0, natB0, -1, eStart);
        waitIdle("idle_after_reset");

        repeat (6) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("queues_drained_dut%0d", d),
                        64'(rdQ[d].size() + wrQ[d].size() + doneQ[d].size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
